// File: rtl/core_pkg.sv
// Shared types and constants for the PC / instruction-fetch controller.
package core_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } state_t;

    // Redirect source IDs; a larger value means higher priority.
    typedef logic [1:0] src_t;
    localparam src_t SRC_NONE = 2'd0;
    localparam src_t SRC_JMP  = 2'd1;
    localparam src_t SRC_BR   = 2'd2;
    localparam src_t SRC_TRAP = 2'd3;

    localparam logic [31:0] DEFAULT_FAULT_VEC = 32'h0000_0010;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/redirect_arb.sv
// Fixed-priority redirect select (trap > branch > jump) with alignment check.
module redirect_arb
    import core_pkg::*;
(
    input  logic        trap,
    input  logic [31:0] trap_pc,
    input  logic        br,
    input  logic [31:0] br_pc,
    input  logic        jmp,
    input  logic [31:0] jmp_pc,
    output logic        taken,
    output logic [31:0] target,
    output src_t        src,
    output logic        misalign
);

    // Pick the highest-priority asserted source.
    always_comb begin
        taken  = 1'b0;
        target = 32'h0;
        src    = SRC_NONE;
        if (trap) begin
            taken  = 1'b1;
            target = trap_pc;
            src    = SRC_TRAP;
        end else if (br) begin
            taken  = 1'b1;
            target = br_pc;
            src    = SRC_BR;
        end else if (jmp) begin
            taken  = 1'b1;
            target = jmp_pc;
            src    = SRC_JMP;
        end
    end

    assign misalign = taken && is_misaligned(target[1:0]);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC sequencing and imem fetch handshake with decode valid/ready hand-off.
//
// state  | meaning
// S_REQ  | issue a fetch at i_pc, or take a redirect / halt instead
// S_WAIT | request outstanding; collect redirects as pending, run timeout
// S_HOLD | instruction presented to decode until consumed or redirected
// S_HALT | debug halt; only i_resume leaves
//
// o_pc_en/o_pc_set/o_pc_target/o_fault are same-cycle decisions; the rest
// are registered. After any o_pc_en pulse the following cycle refuses to
// pulse again (a redirect in S_REQ or a resume is retried one cycle later),
// which also gives the external PC a cycle to update before it is latched.
module pc_fetch_ctrl
    import core_pkg::*;
#(
    parameter int          ACK_TIMEOUT = 16,
    parameter logic [31:0] FAULT_VEC   = DEFAULT_FAULT_VEC
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic [31:0] i_pc,
    output logic        o_pc_en,
    output logic        o_pc_set,
    output logic [31:0] o_pc_target,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    input  logic        i_dec_ready,
    input  logic        i_trap,
    input  logic [31:0] i_trap_pc,
    input  logic        i_br,
    input  logic [31:0] i_br_pc,
    input  logic        i_jmp,
    input  logic [31:0] i_jmp_pc,
    input  logic        i_halt,
    input  logic        i_resume,
    input  logic [31:0] i_resume_pc,
    output logic        o_halted,
    output logic        o_fault
);

    localparam int             CW       = $clog2(ACK_TIMEOUT);
    localparam logic [CW-1:0]  TMO_LOAD = CW'(ACK_TIMEOUT - 1);

    state_t        state, nxt;
    logic          pend_vld;
    src_t          pend_src;
    logic [31:0]   pend_pc;
    logic [CW-1:0] tmo_cnt;
    logic          pc_en_q;

    logic          rd_taken, rd_misalign;
    logic [31:0]   rd_target;
    src_t          rd_src;

    logic          mrg_vld;
    src_t          mrg_src;
    logic [31:0]   mrg_pc;
    logic          tmo_hit;

    logic          pc_en_c, pc_set_c, bad, tmo_fault;
    logic [31:0]   raw;

    redirect_arb u_arb (
        .trap     (i_trap),
        .trap_pc  (i_trap_pc),
        .br       (i_br),
        .br_pc    (i_br_pc),
        .jmp      (i_jmp),
        .jmp_pc   (i_jmp_pc),
        .taken    (rd_taken),
        .target   (rd_target),
        .src      (rd_src),
        .misalign (rd_misalign)
    );

    // Fold this cycle's redirect into the pending one; equal or higher priority wins.
    always_comb begin
        mrg_vld = pend_vld || rd_taken;
        mrg_src = pend_src;
        mrg_pc  = pend_pc;
        if (rd_taken && (!pend_vld || rd_src >= pend_src)) begin
            mrg_src = rd_src;
            mrg_pc  = rd_target;
        end
        tmo_hit = (state == S_WAIT) && !i_imem_ack && (tmo_cnt == '0);
    end

    // Next-state and same-cycle PC update decision.
    always_comb begin
        nxt       = state;
        pc_en_c   = 1'b0;
        pc_set_c  = 1'b0;
        raw       = 32'h0;
        bad       = 1'b0;
        tmo_fault = 1'b0;
        case (state)
            S_REQ: begin
                if (rd_taken) begin
                    nxt = S_REQ;
                    if (!pc_en_q) begin
                        pc_en_c  = 1'b1;
                        pc_set_c = 1'b1;
                        raw      = rd_target;
                        bad      = rd_misalign;
                    end
                end else if (i_halt) begin
                    nxt = S_HALT;
                end else begin
                    nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tmo_hit) begin
                    pc_en_c   = 1'b1;
                    pc_set_c  = 1'b1;
                    raw       = FAULT_VEC;
                    tmo_fault = 1'b1;
                    nxt       = S_REQ;
                end else if (i_imem_ack) begin
                    if (mrg_vld) begin
                        pc_en_c  = 1'b1;
                        pc_set_c = 1'b1;
                        raw      = mrg_pc;
                        bad      = is_misaligned(mrg_pc[1:0]);
                        nxt      = S_REQ;
                    end else begin
                        nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (rd_taken) begin
                    pc_en_c  = 1'b1;
                    pc_set_c = 1'b1;
                    raw      = rd_target;
                    bad      = rd_misalign;
                    nxt      = S_REQ;
                end else if (i_dec_ready) begin
                    pc_en_c = 1'b1;
                    nxt     = i_halt ? S_HALT : S_REQ;
                end
            end
            S_HALT: begin
                if (i_resume && !pc_en_q) begin
                    pc_en_c  = 1'b1;
                    pc_set_c = 1'b1;
                    raw      = i_resume_pc;
                    bad      = is_misaligned(i_resume_pc[1:0]);
                    nxt      = S_REQ;
                end
            end
            default: nxt = S_REQ;
        endcase
    end

    assign o_pc_en     = !i_RST && pc_en_c;
    assign o_pc_set    = !i_RST && pc_set_c;
    assign o_pc_target = i_RST ? 32'h0 : (bad ? FAULT_VEC : raw);
    assign o_fault     = !i_RST && (tmo_fault || bad);

    // State register, fetch handshake, pending redirect and timeout counter.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state        <= S_REQ;
            o_imem_req   <= 1'b0;
            o_imem_addr  <= 32'h0;
            o_inst_valid <= 1'b0;
            o_inst       <= 32'h0;
            o_inst_pc    <= 32'h0;
            o_halted     <= 1'b0;
            pend_vld     <= 1'b0;
            pend_src     <= SRC_NONE;
            pend_pc      <= 32'h0;
            tmo_cnt      <= '0;
            pc_en_q      <= 1'b0;
        end else begin
            state   <= nxt;
            pc_en_q <= pc_en_c;
            case (state)
                S_REQ: begin
                    if (nxt == S_WAIT) begin
                        o_imem_req  <= 1'b1;
                        o_imem_addr <= i_pc;
                        tmo_cnt     <= TMO_LOAD;
                        pend_vld    <= 1'b0;
                    end
                    if (nxt == S_HALT) o_halted <= 1'b1;
                end
                S_WAIT: begin
                    if (nxt != S_WAIT) begin
                        o_imem_req <= 1'b0;
                        pend_vld   <= 1'b0;
                        if (nxt == S_HOLD) begin
                            o_inst_valid <= 1'b1;
                            o_inst       <= i_imem_rdata;
                            o_inst_pc    <= o_imem_addr;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt - CW'(1);
                        if (rd_taken) begin
                            pend_vld <= 1'b1;
                            pend_src <= mrg_src;
                            pend_pc  <= mrg_pc;
                        end
                    end
                end
                S_HOLD: begin
                    if (nxt != S_HOLD) o_inst_valid <= 1'b0;
                    if (nxt == S_HALT) o_halted <= 1'b1;
                end
                S_HALT: begin
                    if (nxt == S_REQ) o_halted <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
